// File: rtl/data_memory_stage.sv
// Memory-access stage: store/load on an internal data memory or ALU pass-through, registered result to write-back.
// Latency 1 cycle (pass-through/store), 2 cycles (load, stall_dm high meanwhile); optional DM_RESET_CLEAR_EN zeroes memory after reset.
module data_memory_stage #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_ex,
    input  logic [DATA_W-1:0] ans_ex,
    input  logic [ADDR_W-1:0] addr_ex,
    input  logic [DATA_W-1:0] data_in,
    input  logic              mem_en,
    input  logic              mem_rw,
    output logic              stall_dm,
    output logic [DATA_W-1:0] ans_dm,
    output logic              valid_dm
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_LOAD_WAIT = 2'd1;
`ifdef DM_RESET_CLEAR_EN
    localparam logic [1:0] S_CLEAR     = 2'd2;
    localparam logic [1:0] RST_STATE   = S_CLEAR;
    localparam logic       RST_STALL   = 1'b1;
`else
    localparam logic [1:0] RST_STATE   = S_IDLE;
    localparam logic       RST_STALL   = 1'b0;
`endif

    logic [DATA_W-1:0] mem [DEPTH];

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] ans_q, ans_d;
    logic              valid_q, valid_d;
    logic              stall_q, stall_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
`ifdef DM_RESET_CLEAR_EN
    logic [IDX_W-1:0]  clr_cnt_q, clr_cnt_d;
`endif

    // Addresses past DEPTH never touch memory; they only matter for non-power-of-two depths.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < 32'(DEPTH);
    endfunction

    always_comb begin
        state_d   = state_q;
        ans_d     = ans_q;
        valid_d   = valid_q;
        stall_d   = stall_q;
        addr_d    = addr_q;
        mem_we    = 1'b0;
        mem_waddr = addr_ex[IDX_W-1:0];
        mem_wdata = data_in;
`ifdef DM_RESET_CLEAR_EN
        clr_cnt_d = clr_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!valid_ex) begin
                    ans_d   = '0;
                    valid_d = 1'b0;
                end else if (!mem_en || mem_rw) begin
                    mem_we  = mem_en && in_range(addr_ex);
                    ans_d   = ans_ex;
                    valid_d = 1'b1;
                end else begin
                    addr_d  = addr_ex;
                    state_d = S_LOAD_WAIT;
                    stall_d = 1'b1;
                    valid_d = 1'b0;
                end
            end
            S_LOAD_WAIT: begin
                ans_d   = in_range(addr_q) ? mem[addr_q[IDX_W-1:0]] : '0;
                valid_d = 1'b1;
                stall_d = 1'b0;
                state_d = S_IDLE;
            end
`ifdef DM_RESET_CLEAR_EN
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_q;
                mem_wdata = '0;
                valid_d   = 1'b0;
                if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
                    clr_cnt_d = '0;
                    stall_d   = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                stall_d = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RST_STATE;
            ans_q     <= '0;
            valid_q   <= 1'b0;
            stall_q   <= RST_STALL;
            addr_q    <= '0;
`ifdef DM_RESET_CLEAR_EN
            clr_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ans_q     <= ans_d;
            valid_q   <= valid_d;
            stall_q   <= stall_d;
            addr_q    <= addr_d;
`ifdef DM_RESET_CLEAR_EN
            clr_cnt_q <= clr_cnt_d;
`endif
        end
    end

    // Memory contents survive reset; only the optional sweep clears them.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign stall_dm = stall_q;
    assign ans_dm   = ans_q;
    assign valid_dm = valid_q;

endmodule

// File: tb/tb_data_memory_stage.sv
// Bench for data_memory_stage: ordered scoreboard of results plus per-scenario inline checks.
module tb_data_memory_stage;

`ifdef DM_RESET_CLEAR_EN
    localparam logic CLR_EN = 1'b1;
`else
    localparam logic CLR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_ex;
    logic [7:0] ans_ex;
    logic [7:0] addr_ex;
    logic [7:0] data_in;
    logic       mem_en;
    logic       mem_rw;
    logic       stall_dm;
    logic [7:0] ans_dm;
    logic       valid_dm;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q [$];
    logic [7:0] model [256];

    data_memory_stage #(.DATA_W(8), .ADDR_W(8), .DEPTH(256)) dut (
        .clk      (clk),
        .reset    (reset),
        .valid_ex (valid_ex),
        .ans_ex   (ans_ex),
        .addr_ex  (addr_ex),
        .data_in  (data_in),
        .mem_en   (mem_en),
        .mem_rw   (mem_rw),
        .stall_dm (stall_dm),
        .ans_dm   (ans_dm),
        .valid_dm (valid_dm)
    );

    always #5 clk = ~clk;

    // Every valid result must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset === 1'b1 && valid_dm === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_unexpected: got ans_dm=%h with no result outstanding", ans_dm);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (ans_dm !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard_data: ans_dm=%h expected %h", ans_dm, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic en, input logic rw,
                          input logic [7:0] a, input logic [7:0] d, input logic [7:0] x);
        valid_ex = v;
        mem_en   = en;
        mem_rw   = rw;
        addr_ex  = a;
        data_in  = d;
        ans_ex   = x;
    endtask

    task automatic store(input logic [7:0] a, input logic [7:0] d, input logic [7:0] x);
        set_in(1'b1, 1'b1, 1'b1, a, d, x);
        exp_q.push_back(x);
        model[a] = d;
    endtask

    task automatic load(input logic [7:0] a);
        set_in(1'b1, 1'b1, 1'b0, a, 8'h00, 8'h99);
        exp_q.push_back(model[a]);
    endtask

    task automatic wait_ready();
`ifdef DM_RESET_CLEAR_EN
        int n;
        n = 0;
        while (stall_dm === 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        n_tests++;
        if (n != 256) begin
            n_fail++;
            $display("FAIL clear_stall_len: stall lasted %0d cycles, expected 256", n);
        end
        for (int i = 0; i < 256; i++) model[i] = 8'h00;
`endif
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set_in(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'hAB);
        tick();
        tick();
        n_tests += 3;
        if (ans_dm !== 8'h00) begin n_fail++; $display("FAIL reset_ans: ans_dm=%h expected 00", ans_dm); end
        if (valid_dm !== 1'b0) begin n_fail++; $display("FAIL reset_valid: valid_dm=%b expected 0", valid_dm); end
        if (stall_dm !== CLR_EN) begin n_fail++; $display("FAIL reset_stall: stall_dm=%b expected %b", stall_dm, CLR_EN); end
        set_in(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        reset = 1'b1;
        wait_ready();
    endtask

    task automatic test_passthrough();
        set_in(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h5A);
        exp_q.push_back(8'h5A);
        tick();
        n_tests += 3;
        if (ans_dm !== 8'h5A) begin n_fail++; $display("FAIL pass_ans: ans_dm=%h expected 5a", ans_dm); end
        if (valid_dm !== 1'b1) begin n_fail++; $display("FAIL pass_valid: valid_dm=%b expected 1", valid_dm); end
        if (stall_dm !== 1'b0) begin n_fail++; $display("FAIL pass_stall: stall_dm=%b expected 0", stall_dm); end
        set_in(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        tick();
        n_tests += 2;
        if (valid_dm !== 1'b0) begin n_fail++; $display("FAIL idle_valid: valid_dm=%b expected 0", valid_dm); end
        if (ans_dm !== 8'h00) begin n_fail++; $display("FAIL idle_ans: ans_dm=%h expected 00", ans_dm); end
    endtask

    task automatic test_store_load();
        store(8'h10, 8'hC3, 8'h3C);
        tick();
        n_tests += 3;
        if (valid_dm !== 1'b1) begin n_fail++; $display("FAIL store_valid: valid_dm=%b expected 1", valid_dm); end
        if (ans_dm !== 8'h3C) begin n_fail++; $display("FAIL store_ans: ans_dm=%h expected 3c", ans_dm); end
        if (stall_dm !== 1'b0) begin n_fail++; $display("FAIL store_stall: stall_dm=%b expected 0", stall_dm); end
        load(8'h10);
        tick();
        n_tests += 3;
        if (stall_dm !== 1'b1) begin n_fail++; $display("FAIL load_stall: stall_dm=%b expected 1", stall_dm); end
        if (valid_dm !== 1'b0) begin n_fail++; $display("FAIL load_wait_valid: valid_dm=%b expected 0", valid_dm); end
        if (ans_dm !== 8'h3C) begin n_fail++; $display("FAIL load_wait_hold: ans_dm=%h expected 3c", ans_dm); end
        set_in(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        tick();
        n_tests += 3;
        if (stall_dm !== 1'b0) begin n_fail++; $display("FAIL load_done_stall: stall_dm=%b expected 0", stall_dm); end
        if (valid_dm !== 1'b1) begin n_fail++; $display("FAIL load_done_valid: valid_dm=%b expected 1", valid_dm); end
        if (ans_dm !== 8'hC3) begin n_fail++; $display("FAIL load_data: ans_dm=%h expected c3", ans_dm); end
        tick();
    endtask

    task automatic test_stall_hold();
        load(8'h10);
        tick();
        set_in(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h77);
        tick();
        n_tests += 2;
        if (ans_dm !== 8'hC3) begin n_fail++; $display("FAIL hold_ans: ans_dm=%h expected c3", ans_dm); end
        if (stall_dm !== 1'b0) begin n_fail++; $display("FAIL hold_stall: stall_dm=%b expected 0", stall_dm); end
        exp_q.push_back(8'h77);
        tick();
        n_tests += 2;
        if (ans_dm !== 8'h77) begin n_fail++; $display("FAIL hold_retake: ans_dm=%h expected 77", ans_dm); end
        if (valid_dm !== 1'b1) begin n_fail++; $display("FAIL hold_retake_valid: valid_dm=%b expected 1", valid_dm); end
        set_in(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        tick();
    endtask

    task automatic test_back_to_back();
        store(8'h20, 8'h5E, 8'h01);
        tick();
        load(8'h20);
        tick();
        load(8'h10);
        tick();
        n_tests += 2;
        if (ans_dm !== 8'h5E) begin n_fail++; $display("FAIL b2b_first: ans_dm=%h expected 5e", ans_dm); end
        if (stall_dm !== 1'b0) begin n_fail++; $display("FAIL b2b_first_stall: stall_dm=%b expected 0", stall_dm); end
        tick();
        set_in(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        n_tests += 2;
        if (valid_dm !== 1'b0) begin n_fail++; $display("FAIL b2b_gap_valid: valid_dm=%b expected 0", valid_dm); end
        if (stall_dm !== 1'b1) begin n_fail++; $display("FAIL b2b_gap_stall: stall_dm=%b expected 1", stall_dm); end
        tick();
        n_tests++;
        if (ans_dm !== 8'hC3 || valid_dm !== 1'b1) begin
            n_fail++; $display("FAIL b2b_second: ans_dm=%h valid_dm=%b expected c3/1", ans_dm, valid_dm);
        end
        tick();
    endtask

    task automatic test_bubble();
        store(8'h30, 8'h11, 8'h02);
        tick();
        set_in(1'b0, 1'b1, 1'b1, 8'h30, 8'hFF, 8'h44);
        tick();
        n_tests += 2;
        if (valid_dm !== 1'b0) begin n_fail++; $display("FAIL bubble_valid: valid_dm=%b expected 0", valid_dm); end
        if (ans_dm !== 8'h00) begin n_fail++; $display("FAIL bubble_ans: ans_dm=%h expected 00", ans_dm); end
        load(8'h30);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        tick();
        n_tests++;
        if (ans_dm !== 8'h11) begin n_fail++; $display("FAIL bubble_no_write: ans_dm=%h expected 11", ans_dm); end
        tick();
    endtask

    task automatic test_reset_mid_load();
        load(8'h20);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        n_tests++;
        if (stall_dm !== 1'b1) begin n_fail++; $display("FAIL midload_stall: stall_dm=%b expected 1", stall_dm); end
        #2;
        reset = 1'b0;
        exp_q.delete();
        #1;
        n_tests += 3;
        if (ans_dm !== 8'h00) begin n_fail++; $display("FAIL midload_ans: ans_dm=%h expected 00", ans_dm); end
        if (valid_dm !== 1'b0) begin n_fail++; $display("FAIL midload_valid: valid_dm=%b expected 0", valid_dm); end
        if (stall_dm !== CLR_EN) begin n_fail++; $display("FAIL midload_rst_stall: stall_dm=%b expected %b", stall_dm, CLR_EN); end
        tick();
        reset = 1'b1;
        wait_ready();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (valid_dm !== 1'b0) begin n_fail++; $display("FAIL midload_no_result: valid_dm=%b expected 0", valid_dm); end
        end
    endtask

`ifdef DM_RESET_CLEAR_EN
    task automatic test_clear();
        store(8'hFF, 8'hAA, 8'h12);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        wait_ready();
        load(8'hFF);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        tick();
        n_tests++;
        if (ans_dm !== 8'h00 || valid_dm !== 1'b1) begin
            n_fail++; $display("FAIL clear_data: ans_dm=%h valid_dm=%b expected 00/1", ans_dm, valid_dm);
        end
        tick();
    endtask
`endif

    initial begin
        reset = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 256; i++) model[i] = 8'h00;
        test_reset();
        test_passthrough();
        test_store_load();
        test_stall_hold();
        test_back_to_back();
        test_bubble();
        test_reset_mid_load();
`ifdef DM_RESET_CLEAR_EN
        test_clear();
`endif
        tick();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d results outstanding, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
